// File: rtl/eq_sweep_pkg.sv
// rtl/eq_sweep_pkg.sv - shared state encoding and settle counter width for the equivalence sweep checker
package eq_sweep_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    DRIVE  = ST_DRIVE,
    SAMPLE = ST_SAMPLE,
    DONE   = ST_DONE
  } sweep_state_t;

endpackage

// File: rtl/eq_settle_counter.sv
// rtl/eq_settle_counter.sv - settle cycle counter with clear, enable and terminal-count flag
module eq_settle_counter
  import eq_sweep_pkg::*;
#(
  parameter int TERMINAL = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [SETTLE_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + SETTLE_W'(1);
    end
  end

  assign tc = (count == SETTLE_W'(TERMINAL));

endmodule

// File: rtl/eq_sweep_checker.sv
// rtl/eq_sweep_checker.sv - exhaustive input sweep comparing two DUT outputs
// Optional EQ_SWEEP_STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
module eq_sweep_checker
  import eq_sweep_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            s_base,
  input  logic            s_eq,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic            fail,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_fail
);

  localparam logic [N_IN-1:0] VEC_LAST = '1;
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE  = (N_IN+1)'(1);

  sweep_state_t    state, state_n;
  logic [N_IN-1:0] vec_n, first_fail_n;
  logic [N_IN:0]   err_cnt_n;
  logic            fail_n;
  logic            cnt_clear, cnt_en, cnt_tc;
  logic            mismatch, sweep_end;

  assign mismatch = s_base ^ s_eq;

  eq_settle_counter #(
    .TERMINAL (SETTLE - 1)
  ) u_settle (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .tc     (cnt_tc)
  );

  always_comb begin
    state_n      = state;
    vec_n        = vec;
    err_cnt_n    = err_cnt;
    fail_n       = fail;
    first_fail_n = first_fail;
    cnt_clear    = 1'b0;
    cnt_en       = 1'b0;
    sweep_end    = (vec == VEC_LAST);
`ifdef EQ_SWEEP_STOP_ON_FAIL_EN
    sweep_end    = sweep_end | mismatch;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n      = DRIVE;
          vec_n        = '0;
          err_cnt_n    = '0;
          fail_n       = 1'b0;
          first_fail_n = '0;
          cnt_clear    = 1'b1;
        end
      end
      DRIVE: begin
        cnt_en = 1'b1;
        if (cnt_tc) state_n = SAMPLE;
      end
      SAMPLE: begin
        if (mismatch) begin
          err_cnt_n = err_cnt + ERR_ONE;
          fail_n    = 1'b1;
          if (!fail) first_fail_n = vec;
        end
        // vec stays on the last sampled vector when the sweep ends
        if (sweep_end) begin
          state_n = DONE;
        end else begin
          state_n   = DRIVE;
          vec_n     = vec + VEC_ONE;
          cnt_clear = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      vec        <= '0;
      err_cnt    <= '0;
      fail       <= 1'b0;
      first_fail <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      vec        <= vec_n;
      err_cnt    <= err_cnt_n;
      fail       <= fail_n;
      first_fail <= first_fail_n;
      busy       <= (state_n == DRIVE) || (state_n == SAMPLE);
      done       <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_eq_sweep_checker.sv
// tb/tb_eq_sweep_checker.sv - scoreboard bench for eq_sweep_checker with random mismatch masks
module tb_eq_sweep_checker;

  localparam int N_IN   = 2;
  localparam int SETTLE = 1;
  localparam int NVEC   = 1 << N_IN;

  logic            clk = 1'b0;
  logic            reset, start, s_base, s_eq;
  logic [N_IN-1:0] vec, first_fail;
  logic [N_IN:0]   err_cnt;
  logic            busy, done, fail;
  logic [NVEC-1:0] mask;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int e0;
    int lat;
    int vec;
    int err;
    int fail;
    int ff;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign s_base = vec[N_IN-1] | ~vec[0];
  assign s_eq   = s_base ^ mask[vec];

  eq_sweep_checker #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .s_base     (s_base),
    .s_eq       (s_eq),
    .vec        (vec),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .err_cnt    (err_cnt),
    .first_fail (first_fail)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: walk the vectors in order, each costing SETTLE+1 cycles.
  function automatic exp_t model(input logic [NVEC-1:0] m, input int e0);
    exp_t r;
    int last;
    r.e0 = e0; r.err = 0; r.fail = 0; r.ff = 0;
    last = NVEC - 1;
    for (int v = 0; v < NVEC; v++) begin
      if (m[v]) begin
        if (r.fail == 0) r.ff = v;
        r.fail = 1;
        r.err++;
`ifdef EQ_SWEEP_STOP_ON_FAIL_EN
        last = v;
        break;
`endif
      end
    end
    r.vec = last;
    r.lat = (last + 1) * (SETTLE + 1);
    return r;
  endfunction

  logic done_d = 1'b0;
  always @(negedge clk) begin
    if (done && !done_d) begin
      if (q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("done_edge", cyc, e.e0 + e.lat);
        check("vec", int'(vec), e.vec);
        check("err_cnt", int'(err_cnt), e.err);
        check("fail", int'(fail), e.fail);
        check("first_fail", int'(first_fail), e.ff);
        check("busy_at_done", int'(busy), 0);
      end
    end
    done_d <= done;
  end

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check("done_timeout", q.size(), 0);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_sweep(input logic [NVEC-1:0] m);
    @(negedge clk);
    mask  = m;
    start = 1'b1;
    q.push_back(model(m, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    wait_drain();
  endtask

  // start held through the first sweep and one edge past its end
  task automatic run_held(input logic [NVEC-1:0] m);
    exp_t first;
    @(negedge clk);
    mask  = m;
    start = 1'b1;
    first = model(m, cyc + 1);
    q.push_back(first);
    q.push_back(model(m, first.e0 + first.lat + 1));
    repeat (first.lat + 2) @(negedge clk);
    start = 1'b0;
    wait_drain();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vec"}, int'(vec), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_fail"}, int'(fail), 0);
    check({tag, "_err_cnt"}, int'(err_cnt), 0);
    check({tag, "_first_fail"}, int'(first_fail), 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    mask  = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    start = 1'b0;

    run_sweep(4'b0000);
    run_sweep(4'b0010);
    run_sweep(4'b1010);
    run_sweep(4'b1111);
    run_sweep(4'b1000);
    repeat (12) run_sweep(NVEC'($urandom_range(0, NVEC - 1)));

    run_held(4'b1010);
    run_held(4'b0000);

    @(negedge clk);
    mask  = 4'b0110;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("no_done_after_reset", int'(done), 0);
    run_sweep(4'b0100);

    check("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
